uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (minimum 4, even).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 SHALL have port rst_n, input, 1, meaning synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port rx, input, 1, meaning raw asynchronous UART line from the pad (idle high).
REQ-006 SHALL have port rd_en, input, 1, meaning pop the head byte this cycle.
REQ-007 SHALL have port rd_data, output, 8, meaning head byte (first-word fall-through).
REQ-008 SHALL have port rx_valid, output, 1, meaning FIFO non-empty.
REQ-009 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning stored byte count.
REQ-010 SHALL have port frame_err, output, 1, meaning sticky flag for a stop bit sampled low.
REQ-011 SHALL have port overrun, output, 1, meaning sticky flag for a byte dropped on a full FIFO.
REQ-012 SHALL have port clr_err, input, 1, meaning clear both sticky flags.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; rx_sync drives all logic.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: rx_sync==0 -> START, bit counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, rx_sync==0 -> DATA with counter cleared; rx_sync==1 -> IDLE (glitch rejected, nothing stored).
REQ-017 DATA: sample rx_sync every CLKS_PER_BIT cycles, shifting LSB-first; after the 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles sample rx_sync; 1 -> push byte, -> IDLE; 0 -> set frame_err, discard byte, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rx_sync==1, then -> IDLE (a break does not retrigger).
REQ-020 Push SHALL occur in the stop-sample cycle; rx_valid/fifo_count SHALL reflect it the next cycle.
REQ-021 rd_en with FIFO empty SHALL be ignored; no underflow, count unchanged.
REQ-022 Push while full without rd_en SHALL drop the new byte and set overrun; stored bytes unchanged.
REQ-023 Push while full with rd_en in the same cycle SHALL succeed (pop then push); overrun not set.
REQ-024 Push and pop on a non-empty, non-full FIFO SHALL leave count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 rd_data SHALL be the oldest stored byte; value is don't-care when rx_valid==0.
REQ-027 clr_err SHALL clear frame_err and overrun next cycle; a same-cycle set SHALL win over clr_err.

Reset
REQ-028 While rst_n==0 at a clk edge: FSM=IDLE, counters=0, synchronizer flops=1, pointers=0, fifo_count=0, rx_valid=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no push; FIFO contents are discarded.
REQ-030 FIFO storage array SHALL need no reset; rd_data is don't-care until the first push.

Structure
REQ-031 Shared package rv32e_periph_pkg SHALL hold the rx state enum and the default CLKS_PER_BIT/FIFO_DEPTH constants.
REQ-032 The buffer SHALL be a separate sub-module sync_fifo, with push, pop, full, empty, count, and FWFT data; the receiver FSM stays in uart_rx_fifo.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-033 Bench SHALL send 0xA5 with stop=1, then check rx_valid=1, rd_data=0xA5, and fifo_count=1; after rd_en for 1 cycle, rx_valid=0.
REQ-034 Bench SHALL drive rx low for 3 cycles while idle, then check that no push occurs and the FSM returns to IDLE.
REQ-035 Bench SHALL send 0x3C with stop=0 and hold rx low for 40 cycles, then check that frame_err=1, nothing is stored, and no new frame starts until rx is high; clr_err then clears frame_err.
REQ-036 Bench SHALL send 5 bytes 0x01..0x05 without reads, then check overrun=1, fifo_count=4, and pops return 0x01..0x04.
REQ-037 Bench SHALL fill the FIFO, assert rd_en in the stop-sample cycle of a 5th byte 0x55, then check overrun=0, count=4, and 0x55 read last.
REQ-038 Bench SHALL assert rst_n=0 for 1 cycle during DATA of a frame, then check all outputs at reset values and a following 0x7E is received correctly.

Source files
------------

// File: rtl/rv32e_periph_pkg.sv
// Shared peripheral definitions: UART receiver state encoding and default sizing.
package rv32e_periph_pkg;

  localparam int DEF_CLKS_PER_BIT = 104;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a small byte FIFO, with sticky framing and overrun flags.
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a falling edge
//   RX_START     | timing to mid start bit, rejecting glitches
//   RX_DATA      | sampling 8 data bits LSB-first, one per bit period
//   RX_STOP      | sampling the stop bit; push byte or flag framing error
//   RX_WAIT_IDLE | after a bad stop bit, wait for the line to return high
module uart_rx_fifo
  import rv32e_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rx_meta, rx_sync;
  logic          push, set_ferr, set_ovr;
  logic          fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_TC) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_sync, shreg[7:1]};
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_TC) begin
          cnt_nxt = '0;
          if (rx_sync) begin
            push      = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            set_ferr  = 1'b1;
            state_nxt = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_sync) state_nxt = RX_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RX_IDLE;
      end
    endcase
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (rd_en),
    .wr_data (shreg),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid = !fifo_empty;
  assign set_ovr  = push && fifo_full && !rd_en;

  // Setting a flag takes priority over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_ferr | (frame_err & ~clr_err);
      overrun   <= set_ovr  | (overrun   & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled as a byte queue plus two sticky flags.
module tb_uart_rx_fifo;

  localparam int CPB       = 8;
  localparam int DEPTH     = 4;
  // Edge (counted from the edge before the start bit is driven) on which the stop bit is sampled.
  localparam int PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       frame_err, overrun;

  int vectors     = 0;
  int miscompares = 0;

  byte unsigned exp_q[$];
  bit           m_ferr, m_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted read is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (rd_en && rst_n) begin
      chk("rd_valid", {31'b0, rx_valid}, {31'b0, exp_q.size() != 0});
      if (rx_valid && exp_q.size() != 0) chk("rd_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    chk({name, ".rx_valid"},   {31'b0, rx_valid},   {31'b0, exp_q.size() != 0});
    chk({name, ".fifo_count"}, {29'b0, fifo_count}, 32'(exp_q.size()));
    chk({name, ".frame_err"},  {31'b0, frame_err},  {31'b0, m_ferr});
    chk({name, ".overrun"},    {31'b0, overrun},    {31'b0, m_ovr});
    if (exp_q.size() != 0) chk({name, ".head"}, {24'b0, rd_data}, {24'b0, exp_q[0]});
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop, input int hold_low,
                            input bit pop_at_stop, input bit clr_at_stop, input int abort_at);
    logic [9:0] bits;
    int cyc;
    bits = {stop, b, 1'b0};
    cyc  = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) begin
        @(posedge clk);
        #1;
        cyc++;
        if (pop_at_stop) rd_en   = (cyc == PUSH_EDGE - 1);
        if (clr_at_stop) clr_err = (cyc == PUSH_EDGE - 1);
        if (abort_at != 0 && cyc == abort_at) rst_n = 1'b0;
        if (abort_at != 0 && cyc == abort_at + 1) begin
          rst_n = 1'b1;
          rx    = 1'b1;
          exp_q.delete();
          m_ferr = 1'b0;
          m_ovr  = 1'b0;
          return;
        end
      end
    end
    if (clr_at_stop) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    if (hold_low > 0) begin
      rx = 1'b0;
      tick(hold_low);
    end
    rx = 1'b1;
    tick(4);
  endtask

  task automatic send(input byte unsigned b);
    send_frame(b, 1'b1, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic read_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
    end
  endtask

  task automatic clear_flags();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; rst_n = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check_status("reset");

    send(8'hA5);
    check_status("a5");
    read_n(1);
    check_status("a5_popped");

    read_n(2);
    check_status("underflow");

    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    tick(12);
    check_status("glitch");
    send(8'h96);
    check_status("after_glitch");
    read_n(1);

    send_frame(8'h3C, 1'b0, 40, 1'b0, 1'b0, 0);
    check_status("frame_err");
    tick(100);
    check_status("no_retrigger");
    clear_flags();
    check_status("clr_frame_err");
    send(8'h5A);
    read_n(1);

    for (int i = 1; i <= 5; i++) send(8'(i));
    check_status("overrun");
    read_n(4);
    check_status("overrun_drained");
    clear_flags();

    for (int i = 0; i < 4; i++) send(8'(8'h11 + i));
    send_frame(8'h55, 1'b1, 0, 1'b1, 1'b0, 0);
    check_status("full_pop_push");
    read_n(4);
    check_status("full_pop_push_drained");

    send_frame(8'h00, 1'b0, 0, 1'b0, 1'b1, 0);
    check_status("set_beats_clear");
    clear_flags();

    send(8'h21);
    send_frame(8'h99, 1'b1, 0, 1'b0, 1'b0, 30);
    check_status("reset_mid_frame");
    send(8'h7E);
    check_status("after_reset");
    read_n(1);

    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 0, 1'b0, 1'b0, 0);
      read_n($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) clear_flags();
      check_status("random");
    end

    n = exp_q.size();
    read_n(n + 1);
    check_status("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
